// File: rtl/data_mem_responder_if.sv
// Request/response channels between the CPU data port and the data memory responder.
interface data_mem_responder_if #(parameter int ADDR_W = 32);
    logic              MEM_req_valid;
    logic              MEM_req_ready;
    logic [1:0]        MEM_write_length;
    logic [1:0]        MEM_read_length;
    logic              MEM_read_signed;
    logic [ADDR_W-1:0] MEM_address;
    logic [31:0]       MEM_write_data;
    logic              MEM_resp_valid;
    logic              MEM_resp_ready;
    logic [31:0]       MEM_read_data;
    logic              MEM_resp_error;

    modport master (
        output MEM_req_valid, MEM_write_length, MEM_read_length, MEM_read_signed,
               MEM_address, MEM_write_data, MEM_resp_ready,
        input  MEM_req_ready, MEM_resp_valid, MEM_read_data, MEM_resp_error
    );

    modport slave (
        input  MEM_req_valid, MEM_write_length, MEM_read_length, MEM_read_signed,
               MEM_address, MEM_write_data, MEM_resp_ready,
        output MEM_req_ready, MEM_resp_valid, MEM_read_data, MEM_resp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised little-endian data RAM answering CPU loads/stores; word-crossing accesses take two beats.
// Define MEM_ALIGN_TRAP_EN to report misaligned accesses as errors instead of splitting them.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input logic                 SYS_clk,
    input logic                 SYS_reset,
    data_mem_responder_if.slave bus
);
    localparam int WIDX_W = ADDR_W - 2;
    localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    typedef struct packed {
        logic              wr;
        logic              err;
        logic              split;
        logic              sgn;
        logic [2:0]        n;
        logic [1:0]        off;
        logic [RAM_AW-1:0] lo_idx;
        logic [RAM_AW-1:0] hi_idx;
        logic [63:0]       wdata;   // store data already shifted onto its byte lanes
        logic [7:0]        be;      // [3:0] low word lanes, [7:4] high word lanes
    } req_t;

    state_t      state;
    req_t        d, r;
    logic        rdy_q, vld_q, err_q;
    logic [31:0] rdata_q, lo_word, rd_word;

    logic              d_wr, d_mis;
    logic [1:0]        d_code;
    logic [WIDX_W-1:0] d_widx, d_hidx;
    logic [7:0]        d_mask;

    always_comb begin
        d_wr   = bus.MEM_write_length != 2'b00;
        d_code = d_wr ? bus.MEM_write_length : bus.MEM_read_length;
        d      = '0;
        d.wr   = d_wr;
        d.sgn  = bus.MEM_read_signed;
        d.off  = bus.MEM_address[1:0];
        case (d_code)
            2'b01:   begin d.n = 3'd1; d_mask = 8'b0000_0001; end
            2'b10:   begin d.n = 3'd2; d_mask = 8'b0000_0011; end
            2'b11:   begin d.n = 3'd4; d_mask = 8'b0000_1111; end
            default: begin d.n = 3'd0; d_mask = 8'b0000_0000; end
        endcase
        d_widx   = bus.MEM_address[ADDR_W-1:2];
        d_hidx   = d_widx + WIDX_W'(1);
        d.lo_idx = d_widx[RAM_AW-1:0];
        d.hi_idx = d_hidx[RAM_AW-1:0];
        d.split  = ({1'b0, d.off} + d.n) > 3'd4;
        d.be     = d_mask << d.off;
        d.wdata  = {32'b0, bus.MEM_write_data} << {d.off, 3'b000};
`ifdef MEM_ALIGN_TRAP_EN
        d_mis = ((d.n == 3'd2) && d.off[0]) || ((d.n == 3'd4) && (d.off != 2'b00));
`else
        d_mis = 1'b0;
`endif
        // n == 0 only arises from an illegal read length code
        d.err = (d.n == 3'd0) || d_mis ||
                (d_widx >= WIDX_W'(DEPTH_WORDS)) ||
                (d.split && (d_hidx >= WIDX_W'(DEPTH_WORDS)));
    end

    function automatic logic [31:0] assemble(input logic [63:0] pair, input logic [1:0] off,
                                             input logic [2:0] n, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(pair >> {off, 3'b000});
        case (n)
            3'd1:    res = {{24{sgn & sh[7]}}, sh[7:0]};
            3'd2:    res = {{16{sgn & sh[15]}}, sh[15:0]};
            3'd4:    res = sh;
            default: res = '0;
        endcase
        return res;
    endfunction

    logic [31:0]       ram [DEPTH_WORDS];
    logic [RAM_AW-1:0] acc_idx;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wd;
    logic              ram_we;

    assign acc_idx = (state == HI) ? r.hi_idx : r.lo_idx;
    assign acc_be  = (state == HI) ? r.be[7:4] : r.be[3:0];
    assign acc_wd  = (state == HI) ? r.wdata[63:32] : r.wdata[31:0];
    assign ram_we  = SYS_reset && r.wr && !r.err && ((state == LO) || (state == HI));
    assign rd_word = ram[acc_idx];

    // RAM has no reset: contents survive SYS_reset
    always_ff @(posedge SYS_clk) begin
        if (ram_we)
            for (int b = 0; b < 4; b++)
                if (acc_be[b]) ram[acc_idx][8*b +: 8] <= acc_wd[8*b +: 8];
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            state   <= IDLE;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (bus.MEM_req_valid && rdy_q) begin
                        r     <= d;
                        rdy_q <= 1'b0;
                        state <= LO;
                    end
                end
                LO: begin
                    lo_word <= rd_word;
                    if (r.split && !r.err) begin
                        state <= HI;
                    end else begin
                        state   <= RESP;
                        vld_q   <= 1'b1;
                        err_q   <= r.err;
                        rdata_q <= (r.err || r.wr) ? '0 : assemble({32'b0, rd_word}, r.off, r.n, r.sgn);
                    end
                end
                HI: begin
                    state   <= RESP;
                    vld_q   <= 1'b1;
                    err_q   <= 1'b0;
                    rdata_q <= r.wr ? '0 : assemble({rd_word, lo_word}, r.off, r.n, r.sgn);
                end
                RESP: begin
                    if (bus.MEM_resp_ready) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MEM_req_ready  = rdy_q;
    assign bus.MEM_resp_valid = vld_q;
    assign bus.MEM_resp_error = err_q;
    assign bus.MEM_read_data  = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-array reference model, randomized loads/stores.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int NBYTES = 4 * DEPTH;

    logic SYS_clk = 1'b0;
    logic SYS_reset = 1'b0;
    data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
        .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .bus(bus));

    always #5 SYS_clk = ~SYS_clk;

    typedef struct { logic [31:0] data; logic err; int lat; int cap; } exp_t;
    exp_t         sb[$];
    byte unsigned model [NBYTES];
    int           vectors = 0, miscompares = 0;
    int           cyc = 0;
    int           rr_mode = 0;   // 0: always ready, 1: random, 2: held low

    always @(posedge SYS_clk) cyc <= cyc + 1;

    always @(posedge SYS_clk) begin
        #1;
        case (rr_mode)
            0:       bus.MEM_resp_ready = 1'b1;
            1:       bus.MEM_resp_ready = 1'($urandom_range(0, 1));
            default: bus.MEM_resp_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int len_bytes(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    // Byte-level view of the memory: range, alignment and extension rules applied directly.
    task automatic model_access(input logic [1:0] wl, input logic [1:0] rl, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] data, output logic err, output bit split);
        bit wr;
        int n;
        longint unsigned a;
        wr    = (wl != 2'b00);
        n     = len_bytes(wr ? wl : rl);
        a     = longint'(addr);
        err   = (n == 0) || (a + longint'(n) > longint'(NBYTES));
`ifdef MEM_ALIGN_TRAP_EN
        if (n != 0 && (a % longint'(n)) != 0) err = 1'b1;
`endif
        split = (a % 4) + longint'(n) > 4;
        data  = '0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < n; i++) model[a + longint'(i)] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) data[8*i +: 8] = model[a + longint'(i)];
                if (sgn && n < 4 && data[8*n-1])
                    for (int i = 8*n; i < 32; i++) data[i] = 1'b1;
            end
        end
    endtask

    // use_k: expected data/error come from the caller's constants instead of the model
    task automatic do_req(input logic [1:0] wl, input logic [1:0] rl, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit use_k, input logic [31:0] k_data, input logic k_err);
        exp_t        e;
        logic [31:0] md;
        logic        me;
        bit          sp;
        int          waitc = 0;
        @(negedge SYS_clk);
        bus.MEM_write_length = wl;
        bus.MEM_read_length  = rl;
        bus.MEM_read_signed  = sgn;
        bus.MEM_address      = addr;
        bus.MEM_write_data   = wd;
        bus.MEM_req_valid    = 1'b1;
        while (!bus.MEM_req_ready && waitc < 50) begin
            @(negedge SYS_clk);
            waitc++;
        end
        check("req_ready_wait", 32'(bus.MEM_req_ready), 32'd1);
        model_access(wl, rl, sgn, addr, wd, md, me, sp);
        e.data = use_k ? k_data : md;
        e.err  = use_k ? k_err : me;
        // counted in edges after capture: one edge per RAM beat
        e.lat  = (sp && !e.err) ? 2 : 1;
        @(posedge SYS_clk);
        #1;
        bus.MEM_req_valid = 1'b0;
        e.cap = cyc;
        sb.push_back(e);
    endtask

    bit          pend = 1'b0;
    exp_t        mon_e;
    logic [31:0] held_d;
    logic        held_e;

    always @(negedge SYS_clk) begin
        if (!SYS_reset) begin
            pend = 1'b0;
        end else begin
            if (bus.MEM_resp_valid && !pend) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(bus.MEM_resp_valid), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("read_data", bus.MEM_read_data, mon_e.data);
                    check("resp_error", 32'(bus.MEM_resp_error), 32'(mon_e.err));
                    check("latency", 32'(cyc - mon_e.cap), 32'(mon_e.lat));
                    check("req_ready_busy", 32'(bus.MEM_req_ready), 32'd0);
                    held_d = bus.MEM_read_data;
                    held_e = bus.MEM_resp_error;
                    pend   = 1'b1;
                end
            end else if (pend) begin
                check("hold_valid", 32'(bus.MEM_resp_valid), 32'd1);
                check("hold_data", bus.MEM_read_data, held_d);
                check("hold_error", 32'(bus.MEM_resp_error), 32'(held_e));
                check("hold_req_ready", 32'(bus.MEM_req_ready), 32'd0);
            end
            if (pend && bus.MEM_resp_valid && bus.MEM_resp_ready) pend = 1'b0;
        end
    end

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || pend) && n < 200) begin
            @(negedge SYS_clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  wl;
        bus.MEM_req_valid    = 1'b0;
        bus.MEM_write_length = 2'b00;
        bus.MEM_read_length  = 2'b00;
        bus.MEM_read_signed  = 1'b0;
        bus.MEM_address      = '0;
        bus.MEM_write_data   = '0;
        for (int i = 0; i < NBYTES; i++) model[i] = 8'h00;

        SYS_reset = 1'b0;
        repeat (2) @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("rst_req_ready", 32'(bus.MEM_req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.MEM_resp_valid), 32'd0);
        check("rst_read_data", bus.MEM_read_data, 32'd0);
        SYS_reset = 1'b1;
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("post_rst_req_ready", 32'(bus.MEM_req_ready), 32'd1);
        check("post_rst_resp_valid", 32'(bus.MEM_resp_valid), 32'd0);
        check("post_rst_read_data", bus.MEM_read_data, 32'd0);
        check("post_rst_error", 32'(bus.MEM_resp_error), 32'd0);

        // give every RAM word a known value
        for (int w = 0; w < DEPTH; w++) do_req(2'b11, 2'b00, 1'b0, 32'(4*w), $urandom, 0, 0, 0);

        do_req(2'b11, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 1'b0);
        do_req(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        do_req(2'b00, 2'b01, 1'b1, 32'h10, 32'h0, 1, 32'hFFFFFFEF, 1'b0);
        do_req(2'b00, 2'b01, 1'b0, 32'h11, 32'h0, 1, 32'h000000BE, 1'b0);
        do_req(2'b00, 2'b10, 1'b1, 32'h12, 32'h0, 1, 32'hFFFFDEAD, 1'b0);
        do_req(2'b00, 2'b10, 1'b0, 32'h12, 32'h0, 1, 32'h0000DEAD, 1'b0);
        do_req(2'b11, 2'b00, 1'b0, 32'h14, 32'h44332211, 1, 32'h0, 1'b0);
`ifdef MEM_ALIGN_TRAP_EN
        do_req(2'b11, 2'b00, 1'b0, 32'h13, 32'hCAFEBABE, 1, 32'h0, 1'b1);
        do_req(2'b00, 2'b11, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        do_req(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        do_req(2'b00, 2'b11, 1'b0, 32'h14, 32'h0, 1, 32'h44332211, 1'b0);
`else
        do_req(2'b11, 2'b00, 1'b0, 32'h13, 32'hCAFEBABE, 1, 32'h0, 1'b0);
        do_req(2'b00, 2'b11, 1'b0, 32'h13, 32'h0, 1, 32'hCAFEBABE, 1'b0);
        do_req(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 1, 32'hBEADBEEF, 1'b0);
        do_req(2'b00, 2'b11, 1'b0, 32'h14, 32'h0, 1, 32'h44CAFEBA, 1'b0);
`endif
        do_req(2'b00, 2'b11, 1'b0, 32'(NBYTES), 32'h0, 1, 32'h0, 1'b1);
        do_req(2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1);
        do_req(2'b11, 2'b00, 1'b0, 32'(NBYTES - 2), 32'h12345678, 1, 32'h0, 1'b1);
        do_req(2'b00, 2'b11, 1'b0, 32'(NBYTES - 4), 32'h0, 0, 0, 0);
        drain();

        // back-pressure: response must stay put while resp_ready is low
        rr_mode = 2;
        do_req(2'b00, 2'b11, 1'b0, 32'h10, 32'h0, 0, 0, 0);
        repeat (7) @(negedge SYS_clk);
        rr_mode = 0;
        drain();

        rr_mode = 1;
        for (int k = 0; k < 300; k++) begin
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
            wl = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            do_req(wl, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 0, 0, 0);
        end
        drain();
        rr_mode = 0;

        // reset while the low beat of a store is in flight
        @(negedge SYS_clk);
        bus.MEM_write_length = 2'b11;
        bus.MEM_read_length  = 2'b00;
        bus.MEM_address      = 32'h13;
        bus.MEM_write_data   = 32'h0BADF00D;
        bus.MEM_req_valid    = 1'b1;
        @(posedge SYS_clk);
        #1;
        bus.MEM_req_valid = 1'b0;
        SYS_reset = 1'b0;
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("midop_rst_resp_valid", 32'(bus.MEM_resp_valid), 32'd0);
        check("midop_rst_req_ready", 32'(bus.MEM_req_ready), 32'd0);
        SYS_reset = 1'b1;
        @(posedge SYS_clk);
        @(negedge SYS_clk);
        check("midop_idle_req_ready", 32'(bus.MEM_req_ready), 32'd1);
        check("midop_idle_resp_valid", 32'(bus.MEM_resp_valid), 32'd0);
        // the abandoned store may have touched words 0x10/0x14; rewrite them so the model agrees
        do_req(2'b11, 2'b00, 1'b0, 32'h10, $urandom, 0, 0, 0);
        do_req(2'b11, 2'b00, 1'b0, 32'h14, $urandom, 0, 0, 0);
        do_req(2'b00, 2'b11, 1'b0, 32'h20, 32'h0, 0, 0, 0);
        do_req(2'b00, 2'b11, 1'b0, 32'h13, 32'h0, 0, 0, 0);
        do_req(2'b00, 2'b10, 1'b1, 32'h16, 32'h0, 0, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data port; the other end of the load/store request that the datapath issues.
- Accepts a request carrying a length code, a signed flag, an address and write data over a valid/ready handshake, then returns a response over a second valid/ready handshake.
- Backed by a word-organised little-endian RAM.
- Misaligned accesses that cross a word boundary are split internally into two word beats.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM.
- ADDR_W, 32, byte-address width.

Ports:
- SYS_clk  in  1  clock; all state updates on its rising edge.
- SYS_reset  in  1  synchronous, active-low reset.
- MEM_req_valid  in  1  request present.
- MEM_req_ready  out  1  responder can accept a request.
- MEM_write_length  in  2  00 = not a write, 01 = byte, 10 = half, 11 = word.
- MEM_read_length  in  2  used only when MEM_write_length == 00; 01 = byte, 10 = half, 11 = word, 00 = illegal.
- MEM_read_signed  in  1  sign-extend byte/half reads.
- MEM_address  in  ADDR_W  byte address for the read or the write.
- MEM_write_data  in  32  store data, right-aligned.
- MEM_resp_valid  out  1  response present.
- MEM_resp_ready  in  1  requester accepts the response.
- MEM_read_data  out  32  load result, right-aligned and extended; 0 for writes and errors.
- MEM_resp_error  out  1  access was out of range or illegal (qualified by MEM_resp_valid).

Behaviour:
- Reset (SYS_reset == 0 at a clock edge):
  - FSM goes to IDLE.
  - MEM_req_ready = 1 after reset releases (0 while held in reset); MEM_resp_valid = 0; MEM_read_data = 0; MEM_resp_error = 0.
  - RAM contents are retained.
  - Reset mid-operation abandons the access. A partial split write may leave the low word already written.
- Request capture: occurs on an edge where MEM_req_valid && MEM_req_ready. Captured fields: op, length n (1/2/4 bytes), signed flag, address, write data. Inputs are ignored at all other times.
- Decode:
  - off = addr[1:0]; widx = addr[ADDR_W-1:2].
  - split = off + n > 4; hidx = widx + 1.
  - Error when:
    - read with MEM_read_length == 00; or
    - widx >= DEPTH_WORDS; or
    - split and hidx >= DEPTH_WORDS.
  - An errored access performs no RAM write and returns data 0.
- FSM states: IDLE, LO, HI, RESP.
  - IDLE: MEM_req_ready = 1. On capture -> LO.
  - LO: access word widx. Write: update byte lanes off..min(off+n-1,3) with the low bytes of the write data. Read: latch the word. Then -> HI if split and no error, else -> RESP.
  - HI: access word hidx. Write: update byte lanes 0..(off+n-5) with the remaining high bytes. Read: latch the word. Then -> RESP.
  - RESP: MEM_resp_valid = 1. Outputs are held stable until MEM_resp_ready; on the handshake edge -> IDLE.
- Latency (capture edge = N):
  - Aligned or non-split access: MEM_resp_valid first high in cycle N+2.
  - Split access: MEM_resp_valid first high in cycle N+3.
  - With MEM_resp_ready tied high: throughput is one request per 3 cycles (non-split), 4 cycles (split).
- MEM_req_ready = 0 in LO, HI and RESP; no overlap between requests.
- Read assembly:
  - Concatenate {hi_word, lo_word} and shift right by 8*off.
  - Take n bytes; sign-extend from bit 8n-1 if signed, else zero-extend.
  - Word reads ignore the signed flag.
- Write and read of the same address in consecutive requests: the read returns the new data.
- Unused bits of MEM_address above the RAM size are only used by the range check; there is no wrap-around.

Optional Feature:
- Macro: MEM_ALIGN_TRAP_EN.
- Defined:
  - Any access with addr mod n != 0 is an error: resp_error = 1, no write, data 0, no HI beat.
  - Aligned accesses can never split, so the HI state is unreachable.
- Undefined: misaligned accesses are split as described in Behaviour.

Test Plan:
- Reset with SYS_reset = 0 for 2 cycles, then release -> req_ready = 1, resp_valid = 0, read_data = 0.
- Write word 0xDEADBEEF @0x10, then read word @0x10 with resp_ready = 1 -> read_data = 0xDEADBEEF, error = 0; resp_valid at N+2 for each request.
- With 0xDEADBEEF @0x10: lb @0x10 signed -> 0xFFFFFFEF; lbu @0x11 -> 0x000000BE; lh @0x12 signed -> 0xFFFFDEAD; lhu @0x12 -> 0x0000DEAD.
- Split cases, with word 0x14 = 0x44332211:
  - sw 0xCAFEBABE @0x13 -> word 0x10 = 0xBEADBEEF and word 0x14 = 0x44CAFEBA.
  - Then lw @0x13 -> 0xCAFEBABE, with resp_valid at N+3.
  - With MEM_ALIGN_TRAP_EN defined, the same sw -> error = 1 and both words unchanged.
- Out of range: read @4*DEPTH_WORDS -> error = 1, data 0. Illegal read_length 00 @0x0 -> error = 1. sw @4*DEPTH_WORDS-2 -> error = 1 and the last word unchanged.
- Back-pressure and reset:
  - Hold resp_ready = 0 for 5 cycles -> resp_valid, read_data and error stable, req_ready = 0.
  - Assert reset during LO of a split write -> next cycle IDLE, resp_valid = 0, and a subsequent read works.
